// File: rtl/tri_edge_setup.sv
// tri_edge_setup: edge-function and signed-area setup for a reoriented triangle on one shared multiplier.
// Define TRI_BACKFACE_CULL_EN to also cull clockwise triangles.
package tri_pkg;
  localparam int TRI_COORD_W = 16;
  typedef struct packed {
    logic signed [TRI_COORD_W-1:0] x;
    logic signed [TRI_COORD_W-1:0] y;
    logic signed [TRI_COORD_W-1:0] z;
  } vertex_t;
  typedef struct packed {
    vertex_t p;
    vertex_t q;
    vertex_t r;
  } triangle3d_t;
endpackage

module tri_edge_setup
  import tri_pkg::*;
#(
  parameter int COORD_W = TRI_COORD_W,
  parameter int CNT_W   = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  triangle3d_t                tri_in,
  output logic                       out_valid,
  input  logic                       out_ready,
  output triangle3d_t                tri_out,
  output logic signed [COORD_W:0]    edge_a0,
  output logic signed [COORD_W:0]    edge_a1,
  output logic signed [COORD_W:0]    edge_a2,
  output logic signed [COORD_W:0]    edge_b0,
  output logic signed [COORD_W:0]    edge_b1,
  output logic signed [COORD_W:0]    edge_b2,
  output logic signed [2*COORD_W:0]  edge_c0,
  output logic signed [2*COORD_W:0]  edge_c1,
  output logic signed [2*COORD_W:0]  edge_c2,
  output logic signed [2*COORD_W+2:0] area2,
  output logic                       cw,
  output logic [CNT_W-1:0]           cull_count
);
  localparam int AW = COORD_W + 1;
  localparam int PW = 2 * COORD_W;
  localparam int CW = 2 * COORD_W + 1;
  localparam int SW = 2 * COORD_W + 3;
  typedef enum logic [1:0] {IDLE, MUL, SUM, OUT} state_t;
  state_t state_q, state_d;
  triangle3d_t tri_q, tri_d;
  logic [2:0] idx_q, idx_d;
  logic signed [PW-1:0] mul_q, mul_d, even_q, even_d;
  logic signed [AW-1:0] a_q [3], a_d [3], b_q [3], b_d [3];
  logic signed [CW-1:0] c_q [3], c_d [3];
  logic signed [SW-1:0] area2_q, area2_d, sum;
  logic cw_q, cw_d, cull, cw_new;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic signed [COORD_W-1:0] op_x, op_y;

  assign in_ready   = state_q == IDLE;
  assign out_valid  = state_q == OUT;
  assign tri_out    = tri_q;
  assign edge_a0    = a_q[0];
  assign edge_a1    = a_q[1];
  assign edge_a2    = a_q[2];
  assign edge_b0    = b_q[0];
  assign edge_b1    = b_q[1];
  assign edge_b2    = b_q[2];
  assign edge_c0    = c_q[0];
  assign edge_c1    = c_q[1];
  assign edge_c2    = c_q[2];
  assign area2      = area2_q;
  assign cw         = cw_q;
  assign cull_count = cnt_q;

  always_comb begin
    state_d = state_q;
    tri_d   = tri_q;
    idx_d   = idx_q;
    mul_d   = mul_q;
    even_d  = even_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    area2_d = area2_q;
    cw_d    = cw_q;
    cnt_d   = cnt_q;
    // product order: xp*yq, xq*yp, xq*yr, xr*yq, xr*yp, xp*yr
    op_x = (idx_q == 3'd0 || idx_q == 3'd5) ? tri_q.p.x : (idx_q < 3'd3) ? tri_q.q.x : tri_q.r.x;
    op_y = (idx_q == 3'd0 || idx_q == 3'd3) ? tri_q.q.y :
           (idx_q == 3'd1 || idx_q == 3'd4) ? tri_q.p.y : tri_q.r.y;
    sum  = SW'(c_q[0]) + SW'(c_q[1]) + SW'(c_q[2]);
`ifdef TRI_BACKFACE_CULL_EN
    cull   = sum[SW-1] || sum == '0;
    cw_new = 1'b0;
`else
    cull   = sum == '0;
    cw_new = sum[SW-1];
`endif
    case (state_q)
      IDLE: if (in_valid) begin
        tri_d   = tri_in;
        idx_d   = 3'd0;
        a_d[0]  = AW'(tri_in.p.y) - AW'(tri_in.q.y);
        a_d[1]  = AW'(tri_in.q.y) - AW'(tri_in.r.y);
        a_d[2]  = AW'(tri_in.r.y) - AW'(tri_in.p.y);
        b_d[0]  = AW'(tri_in.q.x) - AW'(tri_in.p.x);
        b_d[1]  = AW'(tri_in.r.x) - AW'(tri_in.q.x);
        b_d[2]  = AW'(tri_in.p.x) - AW'(tri_in.r.x);
        state_d = MUL;
      end
      MUL: begin
        // product is registered; mul_q lags idx_q by one, so idx 6 drains the last one
        mul_d = PW'(op_x) * PW'(op_y);
        idx_d = idx_q + 3'd1;
        if (idx_q[0]) even_d = mul_q;
        else if (idx_q != 3'd0) c_d[idx_q[2:1] - 2'd1] = CW'(even_q) - CW'(mul_q);
        if (idx_q == 3'd6) state_d = SUM;
      end
      SUM: begin
        area2_d = sum;
        cw_d    = cw_new;
        cnt_d   = (cull && !(&cnt_q)) ? cnt_q + CNT_W'(1) : cnt_q;
        state_d = cull ? IDLE : OUT;
      end
      OUT: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      tri_q   <= '0;
      idx_q   <= '0;
      mul_q   <= '0;
      even_q  <= '0;
      a_q     <= '{default: '0};
      b_q     <= '{default: '0};
      c_q     <= '{default: '0};
      area2_q <= '0;
      cw_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      tri_q   <= tri_d;
      idx_q   <= idx_d;
      mul_q   <= mul_d;
      even_q  <= even_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      area2_q <= area2_d;
      cw_q    <= cw_d;
      cnt_q   <= cnt_d;
    end
  end
endmodule

// File: tb/tb_tri_edge_setup.sv
// tb_tri_edge_setup: randomized self-checking bench for tri_edge_setup against an arithmetic reference model.
module tb_tri_edge_setup;
  import tri_pkg::*;
  localparam int W = 16;
  localparam int CNT_W = 4;
  localparam int VW = 6*(W+1) + 3*(2*W+1) + (2*W+3) + 1 + $bits(triangle3d_t);

  logic clk = 1'b0;
  logic rst, in_valid, in_ready, out_valid, out_ready, cw;
  triangle3d_t tri_in, tri_out;
  logic signed [W:0] edge_a0, edge_a1, edge_a2, edge_b0, edge_b1, edge_b2;
  logic signed [2*W:0] edge_c0, edge_c1, edge_c2;
  logic signed [2*W+2:0] area2;
  logic [CNT_W-1:0] cull_count;
  int checks = 0, passed = 0, exp_cnt = 0;

  tri_edge_setup #(.COORD_W(W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .tri_in(tri_in),
    .out_valid(out_valid), .out_ready(out_ready), .tri_out(tri_out),
    .edge_a0(edge_a0), .edge_a1(edge_a1), .edge_a2(edge_a2),
    .edge_b0(edge_b0), .edge_b1(edge_b1), .edge_b2(edge_b2),
    .edge_c0(edge_c0), .edge_c1(edge_c1), .edge_c2(edge_c2),
    .area2(area2), .cw(cw), .cull_count(cull_count)
  );

  always #5 clk = ~clk;

  function automatic triangle3d_t mk(input int px, py, qx, qy, rx, ry, input int pz = 0, qz = 0, rz = 0);
    triangle3d_t t;
    t.p.x = W'(px); t.p.y = W'(py); t.p.z = W'(pz);
    t.q.x = W'(qx); t.q.y = W'(qy); t.q.z = W'(qz);
    t.r.x = W'(rx); t.r.y = W'(ry); t.r.z = W'(rz);
    return t;
  endfunction

  function automatic longint area_of(input triangle3d_t t);
    longint x[3], y[3], s;
    x = '{longint'(t.p.x), longint'(t.q.x), longint'(t.r.x)};
    y = '{longint'(t.p.y), longint'(t.q.y), longint'(t.r.y)};
    s = 0;
    for (int k = 0; k < 3; k++) s += x[k]*y[(k+1)%3] - x[(k+1)%3]*y[k];
    return s;
  endfunction

  function automatic bit culled(input triangle3d_t t);
`ifdef TRI_BACKFACE_CULL_EN
    return area_of(t) <= 0;
`else
    return area_of(t) == 0;
`endif
  endfunction

  function automatic logic [VW-1:0] exp_vec(input triangle3d_t t);
    longint x[3], y[3], a, b, c, s;
    logic signed [W:0] av[3], bv[3];
    logic signed [2*W:0] cv[3];
    logic signed [2*W+2:0] sv;
    logic cwv;
    x = '{longint'(t.p.x), longint'(t.q.x), longint'(t.r.x)};
    y = '{longint'(t.p.y), longint'(t.q.y), longint'(t.r.y)};
    s = 0;
    for (int k = 0; k < 3; k++) begin
      a = y[k] - y[(k+1)%3];
      b = x[(k+1)%3] - x[k];
      c = x[k]*y[(k+1)%3] - x[(k+1)%3]*y[k];
      s += c;
      av[k] = a[W:0]; bv[k] = b[W:0]; cv[k] = c[2*W:0];
    end
    sv = s[2*W+2:0];
`ifdef TRI_BACKFACE_CULL_EN
    cwv = 1'b0;
`else
    cwv = s < 0;
`endif
    return {av[0], av[1], av[2], bv[0], bv[1], bv[2], cv[0], cv[1], cv[2], sv, cwv, t};
  endfunction

  function automatic logic [VW-1:0] dut_vec();
    return {edge_a0, edge_a1, edge_a2, edge_b0, edge_b1, edge_b2, edge_c0, edge_c1, edge_c2, area2, cw, tri_out};
  endfunction

  function automatic logic [CNT_W-1:0] exp_cull();
    return exp_cnt > 15 ? '1 : CNT_W'(exp_cnt);
  endfunction

  task automatic send(input triangle3d_t t, output int lat, output bit seen);
    tri_in = t; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = -1; seen = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      if (out_valid || in_ready) begin lat = c; seen = out_valid; break; end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; tri_in = '0;
    repeat (2) @(posedge clk);
    #1; rst = 1'b0;
    checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid); else passed++;
    checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready); else passed++;
    checks++; if (cull_count !== '0) $display("FAIL reset_cull_count: got %0d want 0", cull_count); else passed++;
    checks++; if (dut_vec() !== '0) $display("FAIL reset_outputs: got %h want 0", dut_vec()); else passed++;
  endtask

  task automatic test_basic();
    triangle3d_t t = mk(0, 0, 10, 0, 0, 10, 5, -7, 3);
    int lat; bit seen;
    out_ready = 1'b1;
    send(t, lat, seen);
    checks++; if (!seen || lat != 8) $display("FAIL basic_latency: got seen=%b lat=%0d want seen=1 lat=8", seen, lat); else passed++;
    checks++; if (dut_vec() !== exp_vec(t)) $display("FAIL basic_outputs: got %h want %h", dut_vec(), exp_vec(t)); else passed++;
    checks++; if (area2 !== 35'sd100 || cw !== 1'b0) $display("FAIL basic_area: got %0d cw=%b want 100 cw=0", area2, cw); else passed++;
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) $display("FAIL basic_handshake: got valid=%b ready=%b want 0 1", out_valid, in_ready); else passed++;
    out_ready = 1'b0;
  endtask

  task automatic test_cw();
    triangle3d_t t = mk(0, 0, 0, 10, 10, 0);
    int lat; bit seen;
    out_ready = 1'b1;
    send(t, lat, seen);
`ifdef TRI_BACKFACE_CULL_EN
    exp_cnt++;
    checks++; if (seen || lat != 8) $display("FAIL cw_culled: got seen=%b lat=%0d want seen=0 lat=8", seen, lat); else passed++;
    checks++; if (cull_count !== exp_cull()) $display("FAIL cw_cull_count: got %0d want %0d", cull_count, exp_cull()); else passed++;
`else
    checks++; if (!seen || lat != 8) $display("FAIL cw_latency: got seen=%b lat=%0d want seen=1 lat=8", seen, lat); else passed++;
    checks++; if (cw !== 1'b1 || area2 !== -35'sd100) $display("FAIL cw_flag: got cw=%b area2=%0d want cw=1 area2=-100", cw, area2); else passed++;
    checks++; if (dut_vec() !== exp_vec(t)) $display("FAIL cw_outputs: got %h want %h", dut_vec(), exp_vec(t)); else passed++;
    @(posedge clk); #1;
`endif
    out_ready = 1'b0;
  endtask

  task automatic test_degenerate();
    int lat; bit seen;
    out_ready = 1'b1;
    send(mk(0, 0, 5, 5, 10, 10), lat, seen);
    exp_cnt++;
    checks++; if (seen || lat != 8) $display("FAIL degen_no_output: got seen=%b lat=%0d want seen=0 lat=8", seen, lat); else passed++;
    checks++; if (cull_count !== exp_cull()) $display("FAIL degen_cull_count: got %0d want %0d", cull_count, exp_cull()); else passed++;
    out_ready = 1'b0;
  endtask

  task automatic test_extreme();
    triangle3d_t t = mk(-16383, -16383, 16383, 16383, -16383, 16383, -1, 0, 1);
    int lat; bit seen;
    out_ready = 1'b1;
    send(t, lat, seen);
    checks++; if (!seen || lat != 8) $display("FAIL extreme_latency: got seen=%b lat=%0d want seen=1 lat=8", seen, lat); else passed++;
    checks++; if (edge_c0 !== 33'sd0 || edge_c1 !== 33'sd536805378 || edge_c2 !== 33'sd536805378)
      $display("FAIL extreme_c: got %0d %0d %0d want 0 536805378 536805378", edge_c0, edge_c1, edge_c2); else passed++;
    checks++; if (area2 !== 35'sd1073610756) $display("FAIL extreme_area2: got %0d want 1073610756", area2); else passed++;
    checks++; if (dut_vec() !== exp_vec(t)) $display("FAIL extreme_outputs: got %h want %h", dut_vec(), exp_vec(t)); else passed++;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    triangle3d_t t = mk(1, 2, 30, -4, -5, 17, 100, 200, 300);
    int lat; bit seen; bit any;
    out_ready = 1'b0;
    send(t, lat, seen);
    checks++; if (!seen || lat != 8) $display("FAIL bp_latency: got seen=%b lat=%0d want seen=1 lat=8", seen, lat); else passed++;
    tri_in = mk(3, 3, 9, 1, 2, 8); in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0) $display("FAIL bp_hold_%0d: got valid=%b ready=%b want 1 0", i, out_valid, in_ready); else passed++;
      checks++; if (dut_vec() !== exp_vec(t)) $display("FAIL bp_stable_%0d: got %h want %h", i, dut_vec(), exp_vec(t)); else passed++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) $display("FAIL bp_release: got valid=%b ready=%b want 0 1", out_valid, in_ready); else passed++;
    any = 1'b0;
    for (int i = 0; i < 12; i++) begin @(posedge clk); #1; any |= out_valid; end
    checks++; if (any !== 1'b0) $display("FAIL bp_ignored_input: got out_valid=%b want 0", any); else passed++;
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    bit any = 1'b0;
    tri_in = mk(0, 0, 10, 0, 0, 10); in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; exp_cnt = 0;
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) $display("FAIL midrst_state: got ready=%b valid=%b want 1 0", in_ready, out_valid); else passed++;
    checks++; if (cull_count !== '0) $display("FAIL midrst_cull_count: got %0d want 0", cull_count); else passed++;
    for (int i = 0; i < 12; i++) begin @(posedge clk); #1; any |= out_valid; end
    checks++; if (any !== 1'b0) $display("FAIL midrst_no_output: got out_valid=%b want 0", any); else passed++;
    out_ready = 1'b0;
  endtask

  task automatic test_random();
    triangle3d_t t;
    int lat, v[6]; bit seen;
    for (int n = 0; n < 40; n++) begin
      for (int j = 0; j < 6; j++)
        v[j] = n[0] ? int'($urandom_range(0, 65535)) - 32768 : int'($urandom_range(0, 8)) - 4;
      t = mk(v[0], v[1], v[2], v[3], v[4], v[5], int'($urandom_range(0, 999)), 7, -9);
      out_ready = 1'b0;
      send(t, lat, seen);
      if (culled(t)) begin
        exp_cnt++;
        checks++; if (seen || lat != 8) $display("FAIL rnd%0d_cull: got seen=%b lat=%0d want seen=0 lat=8", n, seen, lat); else passed++;
        checks++; if (cull_count !== exp_cull()) $display("FAIL rnd%0d_cull_count: got %0d want %0d", n, cull_count, exp_cull()); else passed++;
      end else begin
        checks++; if (!seen || lat != 8) $display("FAIL rnd%0d_latency: got seen=%b lat=%0d want seen=1 lat=8", n, seen, lat); else passed++;
        checks++; if (dut_vec() !== exp_vec(t)) $display("FAIL rnd%0d_outputs: got %h want %h", n, dut_vec(), exp_vec(t)); else passed++;
        repeat ($urandom_range(0, 3)) @(posedge clk);
        #1;
        checks++; if (out_valid !== 1'b1 || dut_vec() !== exp_vec(t)) $display("FAIL rnd%0d_stall: got %h want %h", n, dut_vec(), exp_vec(t)); else passed++;
        out_ready = 1'b1;
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) $display("FAIL rnd%0d_handshake: got valid=%b ready=%b want 0 1", n, out_valid, in_ready); else passed++;
      end
    end
    out_ready = 1'b0;
  endtask

  task automatic test_saturation();
    int lat, bx, by, dx, dy; bit seen;
    for (int n = 0; n < 18; n++) begin
      bx = int'($urandom_range(0, 200)) - 100; by = int'($urandom_range(0, 200)) - 100;
      dx = int'($urandom_range(0, 40)) - 20;   dy = int'($urandom_range(0, 40)) - 20;
      send(mk(bx, by, bx + dx, by + dy, bx + 3*dx, by + 3*dy), lat, seen);
      exp_cnt++;
      checks++; if (seen || cull_count !== exp_cull()) $display("FAIL sat%0d_cull_count: got seen=%b count=%0d want seen=0 count=%0d", n, seen, cull_count, exp_cull()); else passed++;
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; tri_in = '0;
    test_reset();
    test_basic();
    test_cw();
    test_degenerate();
    test_extreme();
    test_backpressure();
    test_reset_mid();
    test_random();
    test_saturation();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
